// File: rtl/cpu_pkg.sv
// Shared pipeline types: register file widths, load opcode encoding, WB register payload.
package cpu_pkg;

  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_DATA_BUS = 32;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } load_op_t;

  typedef struct packed {
    logic                    valid;
    logic                    wen;
    logic [REG_ADDR_BUS-1:0] waddr;
    logic [REG_DATA_BUS-1:0] result;
    load_op_t                load_op;
    logic [REG_DATA_BUS-1:0] pc;
  } wb_reg_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: pick byte/halfword from a little-endian word and extend it.
module load_ext
  import cpu_pkg::*;
(
  input  logic [REG_DATA_BUS-1:0] word,
  input  logic [1:0]              off,
  input  load_op_t                op,
  output logic [REG_DATA_BUS-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select byte and halfword lanes; halfword ignores off[0] (alignment checked upstream)
  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    data_c = word;
    case (op)
      LD_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_c = {24'd0, byte_sel};
      LD_LH:   data_c = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_c = {16'd0, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: WB pipeline register, stall-safe load data hold, register file write port.
module wb_stage
  import cpu_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    STALL,
  input  logic                    FLUSH,
  input  logic                    MEM_VALID,
  input  logic                    MEM_WEN,
  input  logic [REG_ADDR_BUS-1:0] MEM_WADDR,
  input  logic [REG_DATA_BUS-1:0] MEM_RESULT,
  input  logic [2:0]              MEM_LOAD_OP,
  input  logic [REG_DATA_BUS-1:0] MEM_PC,
  input  logic [REG_DATA_BUS-1:0] DRAM_RDATA,
  output logic                    WEN,
  output logic [REG_ADDR_BUS-1:0] WADDR,
  output logic [REG_DATA_BUS-1:0] WDATA,
  output logic                    WB_VALID,
  output logic [REG_DATA_BUS-1:0] DEBUG_WB_PC
);

  wb_reg_t                 wb_q, wb_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [REG_DATA_BUS-1:0] hold_data_q, hold_data_d;
  logic [REG_DATA_BUS-1:0] eff_word;
  logic [REG_DATA_BUS-1:0] ext_data;

  // Next-state: flush clears, advance captures MEM, first stalled cycle of a load latches SRAM word
  always_comb begin
    wb_d        = wb_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (FLUSH) begin
      wb_d       = '0;
      hold_vld_d = 1'b0;
    end else if (!STALL) begin
      wb_d.valid   = MEM_VALID;
      wb_d.wen     = MEM_WEN;
      wb_d.waddr   = MEM_WADDR;
      wb_d.result  = MEM_RESULT;
      wb_d.load_op = load_op_t'(MEM_LOAD_OP);
      wb_d.pc      = MEM_PC;
      hold_vld_d   = 1'b0;
    end else if (!hold_vld_q && wb_q.valid && (wb_q.load_op != LD_NONE)) begin
      hold_vld_d  = 1'b1;
      hold_data_d = DRAM_RDATA;
    end
  end

  // WB register and hold buffer, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wb_q        <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      wb_q        <= wb_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign eff_word = hold_vld_q ? hold_data_q : DRAM_RDATA;

  load_ext u_load_ext (
    .word   (eff_word),
    .off    (wb_q.result[1:0]),
    .op     (wb_q.load_op),
    .data_c (ext_data)
  );

  // Register file write port and trace outputs
  always_comb begin
    WEN         = wb_q.valid & wb_q.wen & (wb_q.waddr != '0);
    WADDR       = wb_q.waddr;
    WDATA       = (wb_q.load_op == LD_NONE) ? wb_q.result : ext_data;
    WB_VALID    = wb_q.valid;
    DEBUG_WB_PC = wb_q.pc;
  end

endmodule
